rv32i_if_stage: RTL and testbench
=================================

# rv32i_if_stage

Instruction fetch stage of the RV32IM pipeline. It owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions in a small in-order FIFO. It presents {instruction, PC, PC+4} to the IF/ID register feeding the decoder and control unit, and handles stall backpressure and branch/jump redirects from EX, including discarding stale in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
- FIFO_DEPTH, 2, fetch buffer entries; also the cap on buffered plus outstanding fetches (power of two, ≥2)
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  32  fetch address (bits [1:0] always 0)
- i_imem_gnt  in  1  request accepted this cycle (only meaningful with o_imem_req)
- i_imem_rvalid  in  1  response valid; responses return in order, ≥1 cycle after grant
- i_imem_rdata  in  32  instruction word for the response
- i_redirect  in  1  taken branch/jump from EX; flush and refetch
- i_redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- o_valid  out  1  FIFO head holds an instruction
- i_ready  in  1  downstream accepts head this cycle (low = stall)
- o_instr  out  32  head instruction word
- o_pc  out  32  head instruction address
- o_pc_plus4  out  32  o_pc + 4, mod 2^32 (used for JAL/JALR writeback)

## Operation
- State: fetch PC register, outstanding counter (0..FIFO_DEPTH), drop counter (0..FIFO_DEPTH), FIFO of {pc, instr} with read/write pointers and count.
- Issue: o_imem_req = !i_redirect && (fifo_count + outstanding − pop) < FIFO_DEPTH, where pop = o_valid && i_ready. o_imem_addr = fetch PC.
- On o_imem_req && i_imem_gnt: fetch PC += 4 (wraps mod 2^32); outstanding += 1; the issued PC is pushed to an address queue that tracks in-flight PCs.
- On i_imem_rvalid: outstanding −= 1. If drop counter > 0, decrement it and discard the response. Otherwise write {in-flight PC, rdata} to the FIFO tail.
- Pop: when o_valid && i_ready, advance the read pointer. Outputs come directly from the registered FIFO head, with no combinational path from rdata.
- Redirect (i_redirect=1): fetch PC ← {i_redirect_pc[31:2],2'b00}; FIFO emptied; drop counter ← outstanding − (i_imem_rvalid ? 1 : 0); an rvalid in that cycle is discarded; no request is issued in that cycle.
- Simultaneous events:
  - Redirect overrides both pop and push in the same cycle.
  - Grant and rvalid in the same cycle leave the outstanding count unchanged.
  - Push and pop in the same cycle leave the FIFO count unchanged.
- Overflow is impossible by construction. An rvalid with outstanding==0 is a protocol violation and is covered by an assertion.
- No decoding is done here; illegal opcodes pass through to the control unit.

## Timing
- Reset (async assert, sync-deassert-safe) values: fetch PC=RESET_PC, counters=0, FIFO empty.
- Outputs in reset: o_valid=0, o_imem_req=0, o_imem_addr=RESET_PC, o_instr=32'h0000_0013 (NOP), o_pc=RESET_PC, o_pc_plus4=RESET_PC+4.
- First request: o_imem_req=1 in the first cycle after reset release.
- Latency: grant at cycle N, rvalid earliest at N+1, o_valid earliest at N+2.
- Redirect at cycle R: request for the target in R+1; with zero-wait memory, target instruction at o_valid in R+3.
- Throughput: 1 instr/cycle sustained with 1-cycle memory and i_ready=1.
- Stall: o_instr/o_pc are held stable while o_valid && !i_ready.
- Reset mid-operation clears everything immediately. Memory responses arriving after reset release from pre-reset requests are outside the protocol and are not covered.

## Test plan
- Reset then free run: RESET_PC=0, 1-cycle memory, i_ready=1 -> o_pc sequence 0,4,8,… one per cycle from cycle 3; o_pc_plus4=o_pc+4.
- Stall: i_ready=0 for 5 cycles with pc 0x10 at head -> o_pc=0x10 held; o_imem_req drops once buffered+outstanding=2; after release, 0x14 and 0x18 follow with no gap or duplicate.
- Redirect with 2 in flight: 3-cycle-latency memory, i_redirect with target 0x100 -> both old responses dropped; next o_valid has o_pc=0x100, never 0x8/0xC.
- Redirect coinciding with rvalid and pop: same-cycle i_redirect, i_imem_rvalid, i_ready -> FIFO empty next cycle; drop counter = remaining outstanding; first delivered pc is the target.
- Wrap and alignment: redirect to 0xFFFF_FFFE -> o_imem_addr=0xFFFF_FFFC, next 0x0000_0000; o_pc_plus4 for 0xFFFF_FFFC is 0x0.
- Random grant/latency/ready with scoreboard: 10k cycles -> delivered PCs strictly sequential between redirects; no loss, duplication, or overflow; the rvalid-without-outstanding assertion never fires.

Source files
------------

// File: rtl/rv32i_if_stage.sv
// rv32i_if_stage: instruction fetch stage of the RV32IM pipeline.
// Owns the fetch PC, issues word fetches over a req/gnt/rvalid handshake and
// buffers returned instructions in an in-order FIFO feeding the IF/ID register.
// Ports:
//   i_clk, i_rst_n                         clock, async active-low reset
//   o_imem_req/o_imem_addr/i_imem_gnt      fetch request channel
//   i_imem_rvalid/i_imem_rdata             in-order fetch response channel
//   i_redirect/i_redirect_pc               taken branch/jump from EX
//   o_valid/i_ready                        head-of-FIFO handshake to decode
//   o_instr/o_pc/o_pc_plus4                head instruction, its PC, PC+4
module rv32i_if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = PTR_W + 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] aq_rd_q, aq_rd_d;
  logic [PTR_W-1:0] aq_wr_q, aq_wr_d;
  fetch_entry_t     fifo_q [FIFO_DEPTH];
  logic [31:0]      aq_q   [FIFO_DEPTH];

  logic             pop_c;
  logic             issue_c;
  logic             push_c;
  logic [SUM_W-1:0] occ_c;

  // Handshake qualification; occupancy counts buffered plus in-flight fetches,
  // crediting a pop this cycle so full-rate streaming is sustained.
  always_comb begin
    pop_c   = (cnt_q != '0) && i_ready;
    occ_c   = SUM_W'(cnt_q) + SUM_W'(out_q) - SUM_W'(pop_c);
    issue_c = o_imem_req && i_imem_gnt;
    // Responses are written only when not flushing and not owed to a dropped fetch.
    push_c  = i_imem_rvalid && !i_redirect && (drop_q == '0);
  end

  // Next-state logic; a redirect overrides push, pop and issue.
  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q + CNT_W'(issue_c) - CNT_W'(i_imem_rvalid);
    drop_d   = drop_q;
    cnt_d    = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    aq_wr_d  = aq_wr_q + PTR_W'(issue_c);
    aq_rd_d  = aq_rd_q + PTR_W'(i_imem_rvalid);

    if (issue_c) begin
      pc_d = pc_q + 32'd4;
    end

    if (i_redirect) begin
      pc_d     = i_redirect_pc & 32'hFFFF_FFFC;
      // Every fetch still in flight after this cycle belongs to the old path.
      drop_d   = out_q - CNT_W'(i_imem_rvalid);
      cnt_d    = '0;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = rd_ptr_q;
    end else if (i_imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end
  end

  // State registers, FIFO storage and in-flight address queue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      aq_rd_q  <= '0;
      aq_wr_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
        aq_q[i]   <= RESET_PC;
      end
    end else begin
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      aq_rd_q  <= aq_rd_d;
      aq_wr_q  <= aq_wr_d;
      if (issue_c) begin
        aq_q[aq_wr_q] <= pc_q;
      end
      if (push_c) begin
        fifo_q[wr_ptr_q] <= '{pc: aq_q[aq_rd_q], instr: i_imem_rdata};
      end
    end
  end

  // Request is held low in reset so nothing is issued before release.
  assign o_imem_req  = i_rst_n && !i_redirect && (occ_c < SUM_W'(FIFO_DEPTH));
  assign o_imem_addr = pc_q;

  // Decode-side outputs come straight from the registered FIFO head.
  assign o_valid    = (cnt_q != '0);
  assign o_instr    = fifo_q[rd_ptr_q].instr;
  assign o_pc       = fifo_q[rd_ptr_q].pc;
  assign o_pc_plus4 = fifo_q[rd_ptr_q].pc + 32'd4;

  // A response with nothing outstanding breaks the memory protocol.
  a_rvalid_has_outstanding: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(i_imem_rvalid && (out_q == '0))
  );

endmodule

// File: tb/tb_rv32i_if_stage.sv
// tb_rv32i_if_stage: randomized and directed bench for rv32i_if_stage with an
// in-order memory model and a sequential-PC delivery scoreboard.
module tb_rv32i_if_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;

  always #5 clk = ~clk;

  rv32i_if_stage #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_pc_plus4   (o_pc_plus4)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int deliveries = 0;

  // Memory model: granted addresses with the cycle their response is due.
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int gnt_pct = 100;
  int rsp_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  // Reference model: next address to fetch and next PC to be delivered.
  logic [31:0] exp_issue;
  logic [31:0] exp_pc;

  logic        s_valid, s_req;
  logic [31:0] s_pc, s_instr, s_plus4, s_addr;
  bit          prev_stall;
  logic [31:0] prev_pc, prev_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b0;
    mem_addr_q.delete(); mem_due_q.delete();
    exp_issue = RESET_PC; exp_pc = RESET_PC;
    prev_stall = 1'b0; deliveries = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 1;
  endtask

  // One clock cycle: drive at negedge, sample 1 time unit later, score, advance.
  task automatic cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
    int lat;
    i_ready = rdy; i_redirect = redir; i_redirect_pc = tgt;
    i_imem_gnt = ($urandom_range(99) < gnt_pct);
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc && $urandom_range(99) < rsp_pct) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_word(mem_addr_q[0]);
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = $urandom();
    end
    #1;
    s_valid = o_valid; s_req = o_imem_req; s_pc = o_pc;
    s_instr = o_instr; s_plus4 = o_pc_plus4; s_addr = o_imem_addr;

    if (redir) begin
      checks++;
      if (o_imem_req !== 1'b0) begin
        errors++;
        $display("FAIL req_during_redirect cyc=%0d: got %b expected 0", cyc, o_imem_req);
      end
    end
    if (o_imem_req === 1'b1) begin
      checks++;
      if (o_imem_addr !== exp_issue) begin
        errors++;
        $display("FAIL fetch_addr cyc=%0d: got %h expected %h", cyc, o_imem_addr, exp_issue);
      end
    end
    if (prev_stall) begin
      checks++;
      if (o_valid !== 1'b1 || o_pc !== prev_pc || o_instr !== prev_instr) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h ins=%h",
                 cyc, o_valid, o_pc, o_instr, prev_pc, prev_instr);
      end
    end
    if (o_valid === 1'b1 && rdy && !redir) begin
      checks++;
      if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc) || o_pc_plus4 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL delivery cyc=%0d: got pc=%h ins=%h pc4=%h expected pc=%h ins=%h pc4=%h",
                 cyc, o_pc, o_instr, o_pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end
    prev_stall = (o_valid === 1'b1) && !rdy && !redir;
    prev_pc    = o_pc;
    prev_instr = o_instr;

    if (i_imem_rvalid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (o_imem_req === 1'b1 && i_imem_gnt) begin
      lat = $urandom_range(lat_max, lat_min);
      mem_addr_q.push_back(o_imem_addr);
      mem_due_q.push_back(cyc + lat);
      exp_issue = exp_issue + 32'd4;
    end
    if (redir) begin
      exp_issue = tgt & 32'hFFFF_FFFC;
      exp_pc    = tgt & 32'hFFFF_FFFC;
    end
    checks++;
    if (mem_addr_q.size() > int'(FIFO_DEPTH)) begin
      errors++;
      $display("FAIL outstanding_cap cyc=%0d: got %0d expected <= %0d", cyc, mem_addr_q.size(), FIFO_DEPTH);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_redirect = 1'b0; i_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", o_imem_req); end
    checks++; if (o_imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_addr: got %h expected %h", o_imem_addr, RESET_PC); end
    checks++; if (o_instr !== NOP_INSTR) begin errors++; $display("FAIL rst_instr: got %h expected %h", o_instr, NOP_INSTR); end
    checks++; if (o_pc !== RESET_PC) begin errors++; $display("FAIL rst_pc: got %h expected %h", o_pc, RESET_PC); end
    checks++; if (o_pc_plus4 !== RESET_PC + 32'd4) begin errors++; $display("FAIL rst_pc4: got %h expected %h", o_pc_plus4, RESET_PC + 32'd4); end
    rst_n = 1'b1;
    #1;
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", o_imem_req); end
  endtask

  task automatic test_free_run();
    logic [31:0] e;
    gnt_pct = 100; rsp_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      e = 32'(4 * (k - 3));
      checks++;
      if (k < 3 && s_valid !== 1'b0) begin
        errors++; $display("FAIL free_run_early k=%0d: got valid %b expected 0", k, s_valid);
      end else if (k >= 3 && (s_valid !== 1'b1 || s_pc !== e || s_plus4 !== e + 32'd4)) begin
        errors++; $display("FAIL free_run k=%0d: got v=%b pc=%h pc4=%h expected v=1 pc=%h pc4=%h",
                           k, s_valid, s_pc, s_plus4, e, e + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    gnt_pct = 100; rsp_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    for (int k = 1; k <= 6; k++) cycle(1'b1, 1'b0, 32'h0);
    for (int k = 7; k <= 11; k++) begin
      cycle(1'b0, 1'b0, 32'h0);
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'h10 || s_req !== 1'b0) begin
        errors++; $display("FAIL stall k=%0d: got v=%b pc=%h req=%b expected v=1 pc=00000010 req=0",
                           k, s_valid, s_pc, s_req);
      end
    end
    for (int k = 12; k <= 14; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      e = 32'h10 + 32'(4 * (k - 12));
      checks++;
      if (s_valid !== 1'b1 || s_pc !== e) begin
        errors++; $display("FAIL stall_release k=%0d: got v=%b pc=%h expected v=1 pc=%h", k, s_valid, s_pc, e);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    bit found;
    gnt_pct = 100; rsp_pct = 100; lat_min = 3; lat_max = 3;
    reset_dut();
    for (int k = 1; k <= 6; k++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (s_valid === 1'b1) begin
        found = 1'b1;
        checks++;
        if (s_pc !== 32'h100) begin
          errors++; $display("FAIL redirect_first_pc: got %h expected 00000100", s_pc);
        end
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL redirect_timeout: got no valid in 20 cycles expected pc 00000100");
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    gnt_pct = 100; rsp_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    for (int k = 1; k <= 4; k++) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h8) begin
      errors++; $display("FAIL redir_pop_head: got v=%b pc=%h expected v=1 pc=00000008", s_valid, s_pc);
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h200) begin
      errors++; $display("FAIL redir_pop_r1: got v=%b req=%b addr=%h expected v=0 req=1 addr=00000200",
                         s_valid, s_req, s_addr);
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++; $display("FAIL redir_pop_r2: got v=%b expected 0", s_valid);
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h200) begin
      errors++; $display("FAIL redir_pop_r3: got v=%b pc=%h expected v=1 pc=00000200", s_valid, s_pc);
    end
  endtask

  task automatic test_wrap();
    gnt_pct = 100; rsp_pct = 100; lat_min = 1; lat_max = 1;
    reset_dut();
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'hFFFF_FFFE);
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr0: got req=%b addr=%h expected req=1 addr=fffffffc", s_req, s_addr);
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr1: got req=%b addr=%h expected req=1 addr=00000000", s_req, s_addr);
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'hFFFF_FFFC || s_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pc4: got v=%b pc=%h pc4=%h expected v=1 pc=fffffffc pc4=00000000",
                         s_valid, s_pc, s_plus4);
    end
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_plus4 !== 32'h4) begin
      errors++; $display("FAIL wrap_next: got v=%b pc=%h pc4=%h expected v=1 pc=00000000 pc4=00000004",
                         s_valid, s_pc, s_plus4);
    end
  endtask

  task automatic test_random();
    bit rdy, redir;
    gnt_pct = 60; rsp_pct = 70; lat_min = 1; lat_max = 4;
    reset_dut();
    for (int k = 0; k < 10000; k++) begin
      rdy   = ($urandom_range(99) < 70);
      redir = ($urandom_range(99) < 3);
      cycle(rdy, redir, $urandom());
    end
    checks++;
    if (deliveries < 1000) begin
      errors++; $display("FAIL random_progress: got %0d deliveries expected >= 1000", deliveries);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_inflight();
    test_redirect_rvalid_pop();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
